line_encoder_seq: RTL

LINE_ENCODER_SEQ -- requirements
Module: line_encoder_seq

---
 rtl/line_encoder_seq_pkg.sv | 11 +
 rtl/line_encoder_seq_prio_enc.sv | 29 ++
 rtl/line_encoder_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/line_encoder_seq_pkg.sv
// Shared constants for the sequential line encoder: FSM encoding and default vector width.
// Scan order is selected by LINE_ENC_MSB_FIRST_EN (see prio_enc_32).
package line_encoder_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/line_encoder_seq_prio_enc.sv
// Combinational priority encoder: lowest set bit by default, highest set bit when
// LINE_ENC_MSB_FIRST_EN is defined. Also flags whether any bit is set.
module prio_enc_32
  import line_encoder_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             nonzero
);

  // The last match in loop order wins, so the loop runs opposite to the priority.
  always_comb begin
    idx     = '0;
    nonzero = |vec;
`ifdef LINE_ENC_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IW'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
`endif
  end

endmodule

// File: rtl/line_encoder_seq.sv
// Sequential line encoder: captures a request vector and emits the index of each set bit
// through a valid/ready handshake. LINE_ENC_MSB_FIRST_EN selects descending emission order.
module line_encoder_seq
  import line_encoder_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [IW-1:0]    idx,
  output logic             done
);

  logic [1:0]       state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_masked;
  logic [IW-1:0]    load_idx;
  logic             load_nz;
  logic [IW-1:0]    next_idx;
  logic             next_nz;

  // The bit being offered is removed ahead of time so the next index is ready on transfer.
  assign pend_masked = pend & ~(WIDTH'(1) << idx);

  prio_enc_32 #(.WIDTH(WIDTH)) u_load_enc (
    .vec     (d),
    .idx     (load_idx),
    .nonzero (load_nz)
  );

  prio_enc_32 #(.WIDTH(WIDTH)) u_next_enc (
    .vec     (pend_masked),
    .idx     (next_idx),
    .nonzero (next_nz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pend  <= '0;
      valid <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            if (load_nz) begin
              pend  <= d;
              idx   <= load_idx;
              valid <= 1'b1;
              state <= ST_EMIT;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_EMIT: begin
          if (valid && ready) begin
            pend <= pend_masked;
            if (next_nz) begin
              idx <= next_idx;
            end else begin
              valid <= 1'b0;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          pend  <= '0;
          valid <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);

endmodule
